// File: rtl/cpu_id_pipe_if.sv
// Decode-stage bus: IF/WB/EX-side inputs and the ID/EX pipeline register outputs.
// master drives the stage inputs (IF, WB and EX side); slave is the decode stage.
interface cpu_id_pipe_if #(
    parameter int unsigned DATA_W = 32
);
    logic              if_valid;
    logic [DATA_W-1:0] if_pc;
    logic [31:0]       if_inst;
    logic              wb_rfw;
    logic [4:0]        wb_waddr;
    logic [DATA_W-1:0] wb_wdata;
    logic              ex_busy;
    logic              flush;

    logic              c_stall;
    logic              p_valid;
    logic [DATA_W-1:0] p_rfa;
    logic [DATA_W-1:0] p_rfb;
    logic [DATA_W-1:0] p_se;
    logic [4:0]        p_shamt;
    logic [5:0]        p_func;
    logic [4:0]        p_waddr;
    logic              p_rfw;
    logic              p_drw;
    logic              p_j;
    logic              p_b;
    logic              p_jjr;
    logic              p_rfbse;
    logic [1:0]        p_wbsrc;
    logic [5:0]        p_aluop;
    logic [25:0]       p_jaddr;
    logic [DATA_W-1:0] p_pc;
    logic [4:0]        p_rs;
    logic [4:0]        p_rt;

    modport master (
        output if_valid, if_pc, if_inst, wb_rfw, wb_waddr, wb_wdata, ex_busy, flush,
        input  c_stall, p_valid, p_rfa, p_rfb, p_se, p_shamt, p_func, p_waddr,
               p_rfw, p_drw, p_j, p_b, p_jjr, p_rfbse, p_wbsrc, p_aluop, p_jaddr,
               p_pc, p_rs, p_rt
    );

    modport slave (
        input  if_valid, if_pc, if_inst, wb_rfw, wb_waddr, wb_wdata, ex_busy, flush,
        output c_stall, p_valid, p_rfa, p_rfb, p_se, p_shamt, p_func, p_waddr,
               p_rfw, p_drw, p_j, p_b, p_jjr, p_rfbse, p_wbsrc, p_aluop, p_jaddr,
               p_pc, p_rs, p_rt
    );
endinterface

// File: rtl/cpu_id_pipe.sv
// PLP decode stage: register file, decoder, hazard/flush control and ID/EX register.
// Define ID_WB_BYPASS_EN to forward same-cycle WB writes onto the rs/rt read ports.
module cpu_id_pipe #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned NREG   = 32
) (
    input logic           clk,
    input logic           rst,
    cpu_id_pipe_if.slave  bus
);
    localparam int unsigned AW = (NREG > 1) ? $clog2(NREG) : 1;

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] rfa;
        logic [DATA_W-1:0] rfb;
        logic [DATA_W-1:0] se;
        logic [4:0]        shamt;
        logic [5:0]        func;
        logic [4:0]        waddr;
        logic              rfw;
        logic              drw;
        logic              j;
        logic              b;
        logic              jjr;
        logic              rfbse;
        logic [1:0]        wbsrc;
        logic [5:0]        aluop;
        logic [25:0]       jaddr;
        logic [DATA_W-1:0] pc;
        logic [4:0]        rs;
        logic [4:0]        rt;
    } idex_t;

    logic [5:0]        op;
    logic [5:0]        func;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [15:0]       imm;

    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] rfa_rd;
    logic [DATA_W-1:0] rfb_rd;

    idex_t             dec;
    idex_t             idex_q;
    idex_t             idex_d;
    logic              pend_flush_q;
    logic              pend_flush_d;
    logic              lu;
    logic              kill;
    logic              take;

    assign op   = bus.if_inst[31:26];
    assign rs   = bus.if_inst[25:21];
    assign rt   = bus.if_inst[20:16];
    assign rd   = bus.if_inst[15:11];
    assign func = bus.if_inst[5:0];
    assign imm  = bus.if_inst[15:0];

    function automatic logic idx_ok(input logic [4:0] idx);
        return (idx != 5'd0) && (32'(idx) < NREG);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (bus.wb_rfw && idx_ok(bus.wb_waddr)) begin
            regs_q[bus.wb_waddr[AW-1:0]] <= bus.wb_wdata;
        end
    end

    always_comb begin
        rfa_rd = '0;
        rfb_rd = '0;
        if (idx_ok(rs)) rfa_rd = regs_q[rs[AW-1:0]];
        if (idx_ok(rt)) rfb_rd = regs_q[rt[AW-1:0]];
`ifdef ID_WB_BYPASS_EN
        if (bus.wb_rfw && idx_ok(rs) && bus.wb_waddr == rs) rfa_rd = bus.wb_wdata;
        if (bus.wb_rfw && idx_ok(rt) && bus.wb_waddr == rt) rfb_rd = bus.wb_wdata;
`endif
    end

    always_comb begin
        dec       = '0;
        dec.valid = bus.if_valid;
        dec.rfa   = rfa_rd;
        dec.rfb   = rfb_rd;
        dec.se    = (op == 6'h0c || op == 6'h0d) ? {{(DATA_W-16){1'b0}}, imm}
                                                 : {{(DATA_W-16){imm[15]}}, imm};
        dec.shamt = bus.if_inst[10:6];
        dec.func  = func;
        dec.rfw   = !(op == 6'h04 || op == 6'h05 || op == 6'h2b || op == 6'h02);
        if (op == 6'h23)
            dec.wbsrc = 2'd1;
        else if (op == 6'h03 || (op == 6'h00 && func == 6'h09))
            dec.wbsrc = 2'd2;
        else
            dec.wbsrc = 2'd0;
        dec.drw   = (op == 6'h2b);
        dec.rfbse = !(op == 6'h00 || op == 6'h04 || op == 6'h05);
        dec.jjr   = !(op == 6'h02 || op == 6'h03);
        if (op == 6'h03)
            dec.waddr = 5'd31;
        else if (op == 6'h00)
            dec.waddr = rd;
        else
            dec.waddr = rt;
        dec.j     = (op == 6'h02) || (op == 6'h03) ||
                    (op == 6'h00 && (func == 6'h08 || func == 6'h09));
        dec.b     = (op == 6'h04) || (op == 6'h05);
        dec.aluop = op;
        dec.jaddr = bus.if_inst[25:0];
        dec.pc    = bus.if_pc;
        dec.rs    = rs;
        dec.rt    = rt;
    end

    assign lu = idex_q.valid && idex_q.aluop == 6'h23 && idex_q.rt != 5'd0 && bus.if_valid &&
                (idex_q.rt == rs ||
                 (idex_q.rt == rt && (op == 6'h00 || op == 6'h04 || op == 6'h05)));
    assign kill = bus.flush || pend_flush_q;
    assign take = bus.if_valid && !kill && !lu;

    // Kill, load-use bubble and an empty IF slot all collapse to one case:
    // data fields still load, but valid and the side-effecting controls drop.
    always_comb begin
        idex_d = idex_q;
        if (!bus.ex_busy) begin
            idex_d       = dec;
            idex_d.valid = take;
            if (!take) begin
                idex_d.rfw   = 1'b0;
                idex_d.drw   = 1'b0;
                idex_d.j     = 1'b0;
                idex_d.b     = 1'b0;
                idex_d.wbsrc = 2'd0;
            end
        end
    end

    assign pend_flush_d = bus.ex_busy ? (pend_flush_q | bus.flush) : 1'b0;

    always_ff @(posedge clk) begin
        if (rst) begin
            idex_q       <= '0;
            pend_flush_q <= 1'b0;
        end else begin
            idex_q       <= idex_d;
            pend_flush_q <= pend_flush_d;
        end
    end

    assign bus.c_stall = !rst && (bus.ex_busy || (lu && !kill));

    assign bus.p_valid = idex_q.valid;
    assign bus.p_rfa   = idex_q.rfa;
    assign bus.p_rfb   = idex_q.rfb;
    assign bus.p_se    = idex_q.se;
    assign bus.p_shamt = idex_q.shamt;
    assign bus.p_func  = idex_q.func;
    assign bus.p_waddr = idex_q.waddr;
    assign bus.p_rfw   = idex_q.rfw;
    assign bus.p_drw   = idex_q.drw;
    assign bus.p_j     = idex_q.j;
    assign bus.p_b     = idex_q.b;
    assign bus.p_jjr   = idex_q.jjr;
    assign bus.p_rfbse = idex_q.rfbse;
    assign bus.p_wbsrc = idex_q.wbsrc;
    assign bus.p_aluop = idex_q.aluop;
    assign bus.p_jaddr = idex_q.jaddr;
    assign bus.p_pc    = idex_q.pc;
    assign bus.p_rs    = idex_q.rs;
    assign bus.p_rt    = idex_q.rt;
endmodule

// File: doc/cpu_id_pipe.md
Name: cpu_id_pipe

Overview:
- Parametrised instruction-decode stage with a valid-qualified ID/EX pipeline register, for the 5-stage PLP CPU.
- Adds to the previous decode stage:
  - data width and register count parameters;
  - a hold path driven by a busy signal from EX (multi-cycle ALU ops);
  - a flush/bubble path with a pending-flush latch;
  - a posedge register file that is reset to zero;
  - optional WB→ID write-through bypass.
- Sits between IF (which holds on c_stall) and EX.

Parameters:
- DATA_W, 32, datapath/register/PC width (≥32).
- NREG, 32, number of architectural registers (2..32). Indices ≥NREG read as 0; writes to them are ignored.

Ports:
- clk in 1 clock
- rst in 1 synchronous active-high reset
- if_valid in 1 if_inst/if_pc hold a real instruction
- if_pc in DATA_W fetch PC
- if_inst in 32 instruction word
- wb_rfw in 1 writeback enable
- wb_waddr in 5 writeback register
- wb_wdata in DATA_W writeback data
- ex_busy in 1 EX cannot accept a new instruction
- flush in 1 kill the instruction in ID (taken branch/jump)
- c_stall out 1 IF must hold PC/instruction
- p_valid out 1 ID/EX holds a real instruction
- p_rfa, p_rfb out DATA_W rs/rt read data
- p_se out DATA_W extended immediate
- p_shamt out 5 inst[10:6]
- p_func out 6 inst[5:0]
- p_waddr out 5 destination register
- p_rfw, p_drw, p_j, p_b, p_jjr, p_rfbse out 1 controls
- p_wbsrc out 2 0=ALU, 1=mem, 2=link
- p_aluop out 6 opcode
- p_jaddr out 26 inst[25:0]
- p_pc out DATA_W PC
- p_rs, p_rt out 5 source register fields

Behaviour:
- Decode (combinational, from if_inst):
  - rfw=0 for opcodes 04, 05, 2b, 02; otherwise 1.
  - wbsrc: 1 for 23; 2 for 03, or for 00 with func 09; otherwise 0.
  - drw=1 only for 2b.
  - Zero-extend the immediate for 0c/0d; sign-extend it to DATA_W otherwise.
  - rfbse=0 for 00/04/05; otherwise 1.
  - jjr=0 for 02/03; otherwise 1.
  - waddr = 31 for 03, rd for 00, rt otherwise.
  - j=1 for 02, 03, and for 00 with func 08/09.
  - b=1 for 04/05.
- Register file:
  - NREG×DATA_W, written at posedge when wb_rfw && wb_waddr!=0 && wb_waddr<NREG.
  - Reads are combinational; register 0 always reads 0.
  - rst clears all entries.
- Load-use hazard: lu = p_valid && p_aluop==23 && p_rt!=0 && if_valid && (p_rt==rs || (p_rt==rt && op∈{00,04,05})).
- pend_flush register:
  - set when flush && ex_busy;
  - cleared when ex_busy==0;
  - reset value 0.
  - kill = flush || pend_flush.
- Per-cycle priority (posedge, rst=0):
  1. ex_busy=1: ID/EX register holds every field; c_stall=1.
  2. kill: p_valid←0 and all control outputs (rfw, drw, j, b, wbsrc) ←0; data fields are don't-care; c_stall=0.
  3. lu: bubble inserted exactly as for kill; c_stall=1, so IF re-presents the same instruction next cycle.
  4. Otherwise: load the decoded fields; p_valid←if_valid; controls are gated to 0 when if_valid=0.
- c_stall is combinational:
  - c_stall = ex_busy || (lu && !kill).
  - A flush suppresses a load-use stall.
- Latency: 1 cycle from ID to the ID/EX outputs.
- Reset: all p_* outputs 0 and pend_flush 0. While rst=1, c_stall is 0.
- Reset mid-stall: all state clears; nothing resumes.

Optional Feature:
- ID_WB_BYPASS_EN defined:
  - rfa/rfb return wb_wdata when wb_rfw && wb_waddr!=0 && wb_waddr equals the read index (same-cycle write-through).
- Not defined:
  - Reads return the pre-write value.
  - WB results become visible one cycle after the write.

Test Plan:
- Reset, then 1 cycle → all p_* = 0, p_valid=0, c_stall=0; reading r5 via rs returns 0.
- WB writes r3=0x1234 at cycle N, then `add r4,r3,r0` decoded in cycle N:
  - with ID_WB_BYPASS_EN → p_rfa=0x1234;
  - without → p_rfa=0.
  - Decoding it in cycle N+1 gives 0x1234 either way.
- `lw r8,0(r1)` followed by `addu r9,r8,r2` → the cycle after lw enters ID/EX:
  - c_stall=1 and p_valid←0;
  - next cycle addu loads with p_rs=8, p_waddr=9, p_rfw=1.
- Follow `lw r8` with `sw r8,4(r2)` (rt match only) → no stall; p_drw=1, p_rfw=0.
- ex_busy=1 for 3 cycles with `ori r2,r0,0x8000` in ID → ID/EX outputs unchanged, c_stall=1. Then p_se=0x00008000, p_waddr=2.
- Assert flush during ex_busy, then drop ex_busy → the next edge loads p_valid=0 with p_rfw=p_j=0. pend_flush then clears, and the following instruction loads normally.
